// File: rtl/multi_control_ext.sv
// multi_control_ext: multi-cycle MIPS control FSM with memory-ready stalls, extended opcodes and counters
module multi_control_ext #(
    parameter int CNT_W  = 32,
    parameter bit EN_EXT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OP,
    input  logic [5:0]       FUNC,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCWriteCondNeg,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       RegDst,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       state,
    output logic [4:0]       LED,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [3:0] {
        S_IF = 4'd0, S_ID = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXE = 4'd6, S_RWB = 4'd7,
        S_BEQ = 4'd8, S_JMP = 4'd9, S_ADDI = 4'd10, S_ADDIWB = 4'd11,
        S_BNE = 4'd12, S_JAL = 4'd13, S_JR = 4'd14, S_BAD = 4'd15
    } state_t;
    state_t cur, nxt;
    logic [4:0] led_nxt;
    logic bad_op;
    assign state = cur;
    // next state, decoded instruction class and per-state control outputs; reset masks every strobe
    always_comb begin
        nxt = S_IF;
        led_nxt = 5'b0;
        bad_op = 1'b0;
        PCWrite = 1'b0;
        PCWriteCond = 1'b0;
        PCWriteCondNeg = 1'b0;
        IorD = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        IRWrite = 1'b0;
        ALUSrcA = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 2'd0;
        RegDst = 2'd0;
        PCSource = 2'd0;
        ALUOp = 2'd0;
        ALUSrcB = 2'd0;
        case (cur)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                nxt = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                ALUSrcB = 2'd3;
                case (OP)
                    6'b000000:
                        if (FUNC != 6'b001000) begin
                            nxt = S_EXE;
                            led_nxt = 5'b00001;
                        end else if (EN_EXT) begin
                            nxt = S_JR;
                            led_nxt = 5'b10000;
                        end else bad_op = 1'b1;
                    6'b100011, 6'b101011: begin
                        nxt = S_MEMADR;
                        led_nxt = OP[3] ? 5'b00010 : 5'b00100;
                    end
                    6'b000100: begin
                        nxt = S_BEQ;
                        led_nxt = 5'b01000;
                    end
                    6'b000101:
                        if (EN_EXT) begin
                            nxt = S_BNE;
                            led_nxt = 5'b01000;
                        end else bad_op = 1'b1;
                    6'b000010: begin
                        nxt = S_JMP;
                        led_nxt = 5'b10000;
                    end
                    6'b000011:
                        if (EN_EXT) begin
                            nxt = S_JAL;
                            led_nxt = 5'b10000;
                        end else bad_op = 1'b1;
                    6'b001000:
                        if (EN_EXT) begin
                            nxt = S_ADDI;
                            led_nxt = 5'b00001;
                        end else bad_op = 1'b1;
                    default: bad_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                nxt = OP[3] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD = 1'b1;
                nxt = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'd1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD = 1'b1;
                nxt = mem_ready ? S_IF : S_MEMWR;
            end
            S_EXE: begin
                ALUSrcA = 1'b1;
                ALUOp = 2'd2;
                nxt = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst = 2'd1;
            end
            S_BEQ: begin
                ALUSrcA = 1'b1;
                ALUOp = 2'd1;
                PCWriteCond = 1'b1;
                PCSource = 2'd1;
            end
            S_BNE: begin
                ALUSrcA = 1'b1;
                ALUOp = 2'd1;
                PCWriteCondNeg = 1'b1;
                PCSource = 2'd1;
            end
            S_JMP: begin
                PCWrite = 1'b1;
                PCSource = 2'd2;
            end
            S_ADDI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                nxt = S_ADDIWB;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JAL: begin
                RegWrite = 1'b1;
                RegDst = 2'd2;
                MemtoReg = 2'd2;
                PCWrite = 1'b1;
                PCSource = 2'd2;
            end
            S_JR: begin
                PCWrite = 1'b1;
                PCSource = 2'd3;
            end
            default: bad_op = 1'b1;
        endcase
        if (rst) begin
            PCWrite = 1'b0;
            PCWriteCond = 1'b0;
            PCWriteCondNeg = 1'b0;
            IRWrite = 1'b0;
            RegWrite = 1'b0;
            MemRead = 1'b0;
            MemWrite = 1'b0;
        end
    end
    // state register
    always_ff @(posedge clk) begin
        cur <= rst ? S_IF : nxt;
    end
    // class LEDs load on every decode; illegal flag is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            LED <= 5'b0;
            illegal <= 1'b0;
        end else begin
            if (cur == S_ID) LED <= led_nxt;
            if (bad_op) illegal <= 1'b1;
        end
    end
    // wrapping cycle counter and completed-fetch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (cur == S_IF && mem_ready) instr_cnt <= instr_cnt + 1'b1;
        end
    end
endmodule

// File: doc/multi_control_ext.md
# multi_control_ext

Parametrised multi-cycle MIPS control unit, next generation of the existing multi-cycle controller. It adds `bne`, `addi`, `jal` and `jr`, and a memory-ready handshake so that fetch, load and store can stall for slow memory. It also adds cycle and instruction counters plus an illegal-opcode flag for the board display. It sits in the multi-cycle CPU top between the instruction register and the datapath muxes/register enables.

## Interface
Parameters:
- `CNT_W`, default 32: width of `cycle_cnt` and `instr_cnt`.
- `EN_EXT`, default 1: 1 enables `bne`/`addi`/`jal`/`jr`. 0 decodes them as illegal.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `OP` in 6: instruction register [31:26].
- `FUNC` in 6: instruction register [5:0].
- `mem_ready` in 1: memory completes the current access this cycle. Tie to 1 for zero-wait memory.
- `PCWrite`, `PCWriteCond`, `PCWriteCondNeg` out 1 each. Top computes PC enable = `PCWrite | (Zero & PCWriteCond) | (~Zero & PCWriteCondNeg)`.
- `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `ALUSrcA`, `RegWrite` out 1 each.
- `MemtoReg` out 2: 0 = ALUOut, 1 = MDR, 2 = PC.
- `RegDst` out 2: 0 = rt, 1 = rd, 2 = r31.
- `PCSource` out 2: 0 = ALUResult, 1 = ALUOut, 2 = jump address, 3 = A register.
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = funct.
- `ALUSrcB` out 2: 0 = B, 1 = 4, 2 = signext, 3 = signext<<2.
- `state` out 4: current state code.
- `LED` out 5: instruction class, one-hot. [4] jump, [3] branch, [2] lw, [1] sw, [0] R/addi.
- `illegal` out 1: sticky illegal-opcode flag.
- `cycle_cnt` out `CNT_W`: cycles since reset.
- `instr_cnt` out `CNT_W`: instructions fetched since reset.

## Operation
Control outputs are decoded from `state`. Fields not listed for a state are 0.

States, transitions and outputs:
- IF (0): `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=1, `ALUOp`=00, `PCSource`=0.
  - `IRWrite` and `PCWrite` are 1 only while `mem_ready`=1.
  - `mem_ready`=1 → ID; otherwise stay in IF.
- ID (1): `ALUSrcA`=0, `ALUSrcB`=3, `ALUOp`=00. Next state by `OP`:
  - 000000 with `FUNC`=001000 → JR (requires `EN_EXT`).
  - other 000000 → EXE.
  - 100011 or 101011 → MEMADR.
  - 000100 → BEQ.
  - 000101 → BNE.
  - 000010 → JMP.
  - 000011 → JAL.
  - 001000 → ADDI.
  - anything else, or an extended opcode with `EN_EXT`=0 → IF, and set `illegal`.
- MEMADR (2): `ALUSrcA`=1, `ALUSrcB`=2. Next: lw → MEMRD, sw → MEMWR.
- MEMRD (3): `MemRead`=1, `IorD`=1. `mem_ready` → MEMWB; otherwise stay.
- MEMWB (4): `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Next: IF.
- MEMWR (5): `MemWrite`=1, `IorD`=1. `mem_ready` → IF; otherwise stay with `MemWrite` held.
- EXE (6): `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=10. Next: RWB.
- RWB (7): `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Next: IF.
- BEQ (8): `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=1. Next: IF.
- BNE (12): same as BEQ, but `PCWriteCondNeg`=1 instead of `PCWriteCond`. Next: IF.
- JMP (9): `PCWrite`=1, `PCSource`=2. Next: IF.
- ADDI (10): `ALUSrcA`=1, `ALUSrcB`=2, `ALUOp`=00. Next: ADDIWB.
- ADDIWB (11): `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Next: IF.
- JAL (13): `RegWrite`=1, `RegDst`=2, `MemtoReg`=2, `PCWrite`=1, `PCSource`=2. r31 receives PC, which already holds PC+4. Next: IF.
- JR (14): `PCWrite`=1, `PCSource`=3. Next: IF.
- Unused code 15: → IF, and set `illegal`.

Registers:
- `LED` is registered on the ID→next transition with the class of the decoded instruction. It holds until the next ID. An illegal opcode loads 0.
- `cycle_cnt` increments every cycle with `rst`=0.
- `instr_cnt` increments on each IF cycle with `mem_ready`=1.
- Both counters wrap modulo 2^`CNT_W`.
- `illegal` is cleared only by `rst`.

## Timing
- Reset: with `rst`=1 at an edge, the next values are `state`=IF, `LED`=0, `illegal`=0, `cycle_cnt`=0, `instr_cnt`=0.
- While `rst`=1, all write/strobe outputs are forced to 0: `PCWrite`, `PCWriteCond`, `PCWriteCondNeg`, `IRWrite`, `RegWrite`, `MemRead`, `MemWrite`.
- Reset mid-instruction, including during a memory stall, aborts the instruction. No partial write is issued after the reset edge.
- Cycle counts with `mem_ready` held at 1:
  - R-type, addi, lw-stage-less paths: R = 4, addi = 4.
  - lw = 5, sw = 4.
  - beq/bne = 3, j/jal/jr = 3.
  - Each cycle `mem_ready`=0 in IF, MEMRD or MEMWR adds exactly one cycle.
- Handshake:
  - The memory strobe and address select stay stable through the whole stall.
  - `IRWrite`, `PCWrite` in IF and the transition out of MEMRD/MEMWR all occur in the `mem_ready`=1 cycle only.
- `mem_ready` outside IF/MEMRD/MEMWR is ignored.
- Counter wrap: all ones + 1 → 0 in the same cycle, with no flag raised.

## Test plan
- Reset, then `mem_ready`=1 and OP=000000, FUNC=100000.
  - Required: states 0,1,6,7,0.
  - `RegWrite`=1 and `RegDst`=1 only in the state-7 cycle.
  - `instr_cnt`=1 and `cycle_cnt`=4 after the fourth edge.
  - `LED`=00001.
- lw (OP=100011) with `mem_ready` low for 2 cycles in MEMRD.
  - Required: `MemRead`=1 and `IorD`=1 held for 3 cycles, then MEMWB with `MemtoReg`=1.
  - Total 7 cycles.
- jal (OP=000011).
  - Required: state 13 with `RegDst`=2, `MemtoReg`=2, `PCWrite`=1, `PCSource`=2.
  - `LED`=10000.
- bne (OP=000101) vs beq (OP=000100).
  - Required: `PCWriteCondNeg`=1 with `PCWriteCond`=0 in state 12, and the reverse in state 8.
- `EN_EXT`=0, OP=001000.
  - Required: ID→IF, `illegal`=1 and sticky across the following instructions, `LED`=0.
  - Assert `rst`: `illegal`=0.
- `CNT_W`=4, free run 16 cycles, and `rst` asserted during a MEMWR stall.
  - Required: `cycle_cnt` wraps 15→0.
  - On the reset edge, `MemWrite` drops to 0 and `state`=0.
